// File: rtl/inject_sched_9.sv
// Packet-injection scheduler: sweeps router slots, holds each packet until accepted,
// then waits for delivery or timeout. Optional macro INJECT_LFSR_EN selects LFSR data.
module inject_sched_9 #(
  parameter int ROUTERS = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255,
  parameter int GAP_CYC = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             single,
  input  logic                             clear_cnt,
  input  logic [ROUTERS-1:0]               router_ready,
  input  logic                             delivered,
  output logic [ROUTERS*(DATA_W+1)-1:0]    out_to_router,
  output logic [3:0]                       cur_router,
  output logic [DATA_W-1:0]                cur_data,
  output logic [7:0]                       sent_cnt,
  output logic [7:0]                       lost_cnt,
  output logic                             busy
);

  localparam int PKT_W = DATA_W + 1;
  localparam int BUS_W = ROUTERS * PKT_W;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST   = (GAP_CYC == 0) ? 16'd0 : 16'(GAP_CYC - 1);
`ifdef INJECT_LFSR_EN
  localparam logic [DATA_W-1:0] DATA_RST = DATA_W'(1);
`else
  localparam logic [DATA_W-1:0] DATA_RST = '0;
`endif

  typedef enum logic [1:0] {IDLE, INJECT, WAIT, GAP} state_t;

  state_t             state;
  logic               stop_q;
  logic               single_q;
  logic [15:0]        timer;
  logic [3:0]         next_router;
  logic [DATA_W-1:0]  next_data;
  logic               sel_ready;
  logic               stop_now;
  logic               wrap;

  function automatic logic [BUS_W-1:0] slot_bus(input logic [3:0] r,
                                                 input logic [DATA_W-1:0] d);
    logic [BUS_W-1:0] b;
    b = '0;
    for (int i = 0; i < ROUTERS; i++)
      if (r == 4'(i)) b[i*PKT_W +: PKT_W] = {1'b1, d};
    return b;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < ROUTERS; i++)
      if (cur_router == 4'(i)) sel_ready = router_ready[i];
    stop_now    = stop_q | stop;
    wrap        = (cur_router == 4'(ROUTERS - 1));
    next_router = wrap ? 4'd0 : cur_router + 4'd1;
`ifdef INJECT_LFSR_EN
    next_data   = {cur_data[6:0], cur_data[7] ^ cur_data[5] ^ cur_data[4] ^ cur_data[3]};
`else
    next_data   = wrap ? cur_data + DATA_W'(1) : cur_data;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments
  // in this block override earlier ones, which gives clear_cnt its priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      out_to_router <= '0;
      cur_router    <= '0;
      cur_data      <= DATA_RST;
      sent_cnt      <= '0;
      lost_cnt      <= '0;
      busy          <= 1'b0;
      stop_q        <= 1'b0;
      single_q      <= 1'b0;
      timer         <= '0;
    end else begin
      if (stop && busy) stop_q <= 1'b1;
      case (state)
        IDLE: begin
          out_to_router <= '0;
          if (start) begin
            state         <= INJECT;
            busy          <= 1'b1;
            single_q      <= single;
            stop_q        <= 1'b0;
            out_to_router <= slot_bus(cur_router, cur_data);
          end
        end
        INJECT: begin
          if (stop_now) begin
            // Abort before transfer: packet is dropped, nothing counted.
            state         <= IDLE;
            busy          <= 1'b0;
            out_to_router <= '0;
          end else if (sel_ready) begin
            state         <= WAIT;
            timer         <= '0;
            out_to_router <= '0;
          end
        end
        WAIT: begin
          timer <= timer + 16'd1;
          if (delivered) begin
            sent_cnt <= sat_inc(sent_cnt);
            state    <= GAP;
            timer    <= '0;
          end else if (timer == TIMER_LAST) begin
            lost_cnt <= sat_inc(lost_cnt);
            state    <= GAP;
            timer    <= '0;
          end
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            timer      <= '0;
            cur_router <= next_router;
            cur_data   <= next_data;
            if (stop_now || single_q) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state         <= INJECT;
              out_to_router <= slot_bus(next_router, next_data);
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (clear_cnt) begin
        sent_cnt <= '0;
        lost_cnt <= '0;
      end
    end
  end

endmodule
